// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch predictor with 2-bit counters, init sweep and mispredict redirect
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            f_valid,
  input  logic [XLEN-1:0] f_pc,
  output logic            p_valid,
  output logic            p_taken,
  output logic [XLEN-1:0] p_target,
  input  logic            u_valid,
  input  logic [XLEN-1:0] u_pc,
  input  logic            u_taken,
  input  logic [XLEN-1:0] u_target,
  input  logic            u_pred_taken,
  input  logic [XLEN-1:0] u_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mp_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = XLEN - IDX_BITS - 2;

  typedef enum logic {INIT, RUN} state_e;

  state_e                state_q;
  logic [IDX_BITS-1:0]   sweep_idx_q;
  logic                  ready_q;
  logic                  p_valid_q;
  logic                  p_taken_q;
  logic [XLEN-1:0]       p_target_q;
  logic                  mispredict_q;
  logic [XLEN-1:0]       redirect_pc_q;
  logic [31:0]           br_count_q;
  logic [31:0]           mp_count_q;

  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [XLEN-1:0]       target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0]   f_idx;
  logic [TAG_W-1:0]      f_tag;
  logic                  f_pred_taken;
  logic [IDX_BITS-1:0]   u_idx;
  logic [TAG_W-1:0]      u_tag;
  logic                  u_hit;
  logic [1:0]            u_ctr_d;
  logic                  mp_cond;
  logic                  unused_pc_bits;

  assign f_idx = f_pc[IDX_BITS+1:2];
  assign f_tag = f_pc[XLEN-1:IDX_BITS+2];
  assign u_idx = u_pc[IDX_BITS+1:2];
  assign u_tag = u_pc[XLEN-1:IDX_BITS+2];
  assign unused_pc_bits = ^{f_pc[1:0], u_pc[1:0]};

  assign f_pred_taken = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && ctr_q[f_idx][1];
  assign u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign mp_cond      = (u_taken != u_pred_taken) || (u_taken && (u_pred_target != u_target));

  always_comb begin
    u_ctr_d = ctr_q[u_idx];
    if (u_hit) begin
      if (u_taken) begin
        if (ctr_q[u_idx] != 2'b11) u_ctr_d = ctr_q[u_idx] + 2'b01;
      end else begin
        if (ctr_q[u_idx] != 2'b00) u_ctr_d = ctr_q[u_idx] - 2'b01;
      end
    end else begin
      u_ctr_d = u_taken ? 2'b10 : 2'b01;
    end
  end

  // Table storage is cleared by the sweep, not by rst; reads above see pre-edge contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        valid_q[sweep_idx_q]  <= 1'b0;
        tag_q[sweep_idx_q]    <= '0;
        target_q[sweep_idx_q] <= '0;
        ctr_q[sweep_idx_q]    <= 2'b01;
      end else if (u_valid) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        ctr_q[u_idx]   <= u_ctr_d;
        if (u_taken || !u_hit) target_q[u_idx] <= u_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT;
      sweep_idx_q   <= '0;
      ready_q       <= 1'b0;
      p_valid_q     <= 1'b0;
      p_taken_q     <= 1'b0;
      p_target_q    <= '0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      br_count_q    <= '0;
      mp_count_q    <= '0;
    end else begin
      case (state_q)
        INIT: begin
          p_valid_q    <= 1'b0;
          p_taken_q    <= 1'b0;
          p_target_q   <= '0;
          mispredict_q <= 1'b0;
          sweep_idx_q  <= sweep_idx_q + 1'b1;
          if (sweep_idx_q == '1) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          p_valid_q    <= f_valid;
          p_taken_q    <= f_valid && f_pred_taken;
          if (!f_valid)          p_target_q <= '0;
          else if (f_pred_taken) p_target_q <= target_q[f_idx];
          else                   p_target_q <= f_pc + XLEN'(4);
          mispredict_q <= u_valid && mp_cond;
          if (u_valid) begin
            redirect_pc_q <= u_taken ? u_target : u_pc + XLEN'(4);
            if (br_count_q != 32'hFFFF_FFFF) br_count_q <= br_count_q + 32'd1;
            if (mp_cond && (mp_count_q != 32'hFFFF_FFFF)) mp_count_q <= mp_count_q + 32'd1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign ready       = ready_q;
  assign p_valid     = p_valid_q;
  assign p_taken     = p_taken_q;
  assign p_target    = p_target_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign br_count    = br_count_q;
  assign mp_count    = mp_count_q;

endmodule
